// File: rtl/sound_sample_arbiter.sv
// sound_sample_arbiter: shares one w_sound-bit sound path between n_src requesters.
// A free-running counter produces the sample-rate tick; on each tick one eligible
// source is granted round-robin and its sample is registered onto sound.
// Optional macro SOUND_ARB_HOLD_LAST_EN: on underrun keep the previous sample
// instead of emitting silence.
module sound_sample_arbiter #(
  parameter int unsigned clk_mhz        = 27,
  parameter int unsigned sample_rate_hz = 48000,
  parameter int unsigned n_src          = 4,
  parameter int unsigned w_sound        = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [n_src-1:0]           src_en,
  input  logic [n_src-1:0]           src_valid,
  input  logic [n_src*w_sound-1:0]   src_sample,
  output logic [n_src-1:0]           src_ready,
  output logic [w_sound-1:0]         sound,
  output logic                       sound_strobe,
  output logic [$clog2(n_src):0]     grant_id,
  output logic [15:0]                underrun_cnt
);

  localparam int unsigned P  = (clk_mhz * 1000000) / sample_rate_hz;
  localparam int unsigned CW = $clog2(P);
  localparam int unsigned GW = $clog2(n_src) + 1;

  typedef enum logic [1:0] {S_WAIT, S_GRANT, S_EMIT} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               tick_c;
  logic [w_sound-1:0] sound_q, sound_d;
  logic               strobe_q, strobe_d;
  logic [GW-1:0]      grant_q, grant_d;
  logic [15:0]        underrun_q, underrun_d;
  logic [n_src-1:0]   elig;
  logic               found;
  logic [GW-1:0]      win;
  logic [w_sound-1:0] win_sample;

  // Sample-rate tick: counter never stalls, so the period is exactly P cycles.
  always_comb begin
    tick_c = (cnt_q == CW'(P - 1));
    cnt_d  = tick_c ? '0 : cnt_q + CW'(1);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_WAIT;
    else        state_q <= state_d;
  end

  // Next-state logic: WAIT -> GRANT on tick -> EMIT -> WAIT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT:  if (tick_c) state_d = S_GRANT;
      S_GRANT: state_d = S_EMIT;
      S_EMIT:  state_d = S_WAIT;
      default: state_d = S_WAIT;
    endcase
  end

  // Round-robin search starting just after the last granted index.
  always_comb begin
    elig       = src_valid & src_en;
    found      = 1'b0;
    win        = '0;
    win_sample = '0;
    for (int k = 0; k < int'(n_src); k++) begin
      for (int i = 0; i < int'(n_src); i++) begin
        if (!found && (i == ((int'(grant_q) + 1 + k) % int'(n_src))) && elig[i]) begin
          found = 1'b1;
          win   = GW'(i);
        end
      end
    end
    for (int i = 0; i < int'(n_src); i++) begin
      if (win == GW'(i)) win_sample = src_sample[i*w_sound +: w_sound];
    end
  end

  // Output logic: grant handshake and next values of the registered outputs.
  always_comb begin
    src_ready  = '0;
    sound_d    = sound_q;
    strobe_d   = 1'b0;
    grant_d    = grant_q;
    underrun_d = underrun_q;
    if (state_q == S_GRANT) begin
      strobe_d = 1'b1;
      if (found) begin
        for (int i = 0; i < int'(n_src); i++) src_ready[i] = (win == GW'(i));
        sound_d = win_sample;
        grant_d = win;
      end else begin
        underrun_d = (underrun_q == 16'hFFFF) ? underrun_q : underrun_q + 16'd1;
`ifdef SOUND_ARB_HOLD_LAST_EN
        sound_d = sound_q;
`else
        sound_d = '0;
`endif
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      sound_q    <= '0;
      strobe_q   <= 1'b0;
      grant_q    <= GW'(n_src - 1);
      underrun_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      sound_q    <= sound_d;
      strobe_q   <= strobe_d;
      grant_q    <= grant_d;
      underrun_q <= underrun_d;
    end
  end

  assign sound        = sound_q;
  assign sound_strobe = strobe_q;
  assign grant_id     = grant_q;
  assign underrun_cnt = underrun_q;

endmodule

// File: tb/tb_sound_sample_arbiter.sv
// Self-checking bench for sound_sample_arbiter (P=10, n_src=4, w_sound=16).
// Expected strobes are queued when stimulus is applied and checked as they arrive.
module tb_sound_sample_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  src_en;
  logic [3:0]  src_valid;
  logic [63:0] src_sample;
  logic [3:0]  src_ready;
  logic [15:0] sound;
  logic        sound_strobe;
  logic [2:0]  grant_id;
  logic [15:0] underrun_cnt;

  sound_sample_arbiter #(
    .clk_mhz(1), .sample_rate_hz(100000), .n_src(4), .w_sound(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .src_en(src_en), .src_valid(src_valid),
    .src_sample(src_sample), .src_ready(src_ready), .sound(sound),
    .sound_strobe(sound_strobe), .grant_id(grant_id), .underrun_cnt(underrun_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

`ifdef SOUND_ARB_HOLD_LAST_EN
  localparam logic [15:0] UND_SOUND = 16'h1234;
`else
  localparam logic [15:0] UND_SOUND = 16'h0000;
`endif

  typedef struct packed {
    logic [15:0] snd;
    logic [2:0]  gid;
    logic [3:0]  rdy;
    logic [7:0]  gap;
  } exp_t;

  exp_t       sb[$];
  int         vectors = 0;
  int         fails   = 0;
  int         last_cyc = 0;
  logic [3:0] ready_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] snd, input logic [2:0] gid,
                      input logic [3:0] rdy, input logic [7:0] gap);
    sb.push_back(exp_t'{snd, gid, rdy, gap});
  endtask

  task automatic wait_strobe(output bit ok);
    ok = 1'b0;
    ready_seen = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (src_ready != 4'b0) ready_seen = src_ready;
      if (sound_strobe) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic expect_strobe(input string tag);
    exp_t e;
    bit   ok;
    if (sb.size() == 0) begin
      vectors++;
      fails++;
      $error("FAIL %s: scoreboard empty, observed 0 expected 1 entries", tag);
      return;
    end
    e = sb.pop_front();
    wait_strobe(ok);
    check({tag, "_strobe"}, 32'(ok), 32'd1);
    if (ok) begin
      check({tag, "_sound"}, 32'(sound), 32'(e.snd));
      check({tag, "_grant"}, 32'(grant_id), 32'(e.gid));
      check({tag, "_ready"}, 32'(ready_seen), 32'(e.rdy));
      check({tag, "_gap"}, 32'(cyc - last_cyc), 32'(e.gap));
      last_cyc = cyc;
    end
  endtask

  task automatic set_samples(input logic [15:0] s0);
    src_sample = {16'h1003, 16'h1002, 16'h1001, s0};
  endtask

  initial begin
    bit got;
    rst_n     = 1'b0;
    src_en    = 4'hF;
    src_valid = 4'hF;
    set_samples(16'h1000);
    repeat (2) @(negedge clk);
    check("rst_sound", 32'(sound), 32'h0);
    check("rst_strobe", 32'(sound_strobe), 32'h0);
    check("rst_grant", 32'(grant_id), 32'h3);
    check("rst_underrun", 32'(underrun_cnt), 32'h0);
    check("rst_ready", 32'(src_ready), 32'h0);
    rst_n = 1'b1;
    last_cyc = cyc;

    // All sources eligible: strict rotation, first strobe 11 cycles after release.
    push(16'h1000, 3'd0, 4'b0001, 8'd11);
    push(16'h1001, 3'd1, 4'b0010, 8'd10);
    push(16'h1002, 3'd2, 4'b0100, 8'd10);
    push(16'h1003, 3'd3, 4'b1000, 8'd10);
    push(16'h1000, 3'd0, 4'b0001, 8'd10);
    repeat (5) expect_strobe("rot");

    // Only source 2 valid.
    src_valid  = 4'b0100;
    src_sample = {16'h1003, 16'h7FFF, 16'h1001, 16'h1000};
    repeat (3) push(16'h7FFF, 3'd2, 4'b0100, 8'd10);
    repeat (3) expect_strobe("only2");
    check("only2_underrun", 32'(underrun_cnt), 32'h0);

    // Enable mask 1010: alternate between 3 and 1.
    src_valid = 4'hF;
    src_en    = 4'b1010;
    set_samples(16'h1000);
    push(16'h1003, 3'd3, 4'b1000, 8'd10);
    push(16'h1001, 3'd1, 4'b0010, 8'd10);
    push(16'h1003, 3'd3, 4'b1000, 8'd10);
    push(16'h1001, 3'd1, 4'b0010, 8'd10);
    repeat (4) expect_strobe("mask");

    // Load 1234 from source 0, then three empty ticks.
    src_en    = 4'hF;
    src_valid = 4'b0001;
    set_samples(16'h1234);
    push(16'h1234, 3'd0, 4'b0001, 8'd10);
    expect_strobe("load");
    src_valid = 4'b0000;
    repeat (3) push(UND_SOUND, 3'd0, 4'b0000, 8'd10);
    repeat (3) expect_strobe("under");
    check("under_cnt3", 32'(underrun_cnt), 32'h3);

    // Saturation: preload the counter just below full.
    force dut.underrun_q = 16'hFFFE;
    @(negedge clk);
    release dut.underrun_q;
    for (int t = 0; t < 3; t++) begin
      push(UND_SOUND, 3'd0, 4'b0000, 8'd10);
      expect_strobe("sat");
      check("sat_cnt", 32'(underrun_cnt), 32'hFFFF);
    end

    // Reset in the middle of a grant cycle.
    src_valid = 4'b0010;
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (src_ready != 4'b0) begin
        got = 1'b1;
        break;
      end
    end
    check("rstg_grant_seen", 32'(got), 32'h1);
    rst_n = 1'b0;
    #1;
    check("rstg_ready", 32'(src_ready), 32'h0);
    check("rstg_sound", 32'(sound), 32'h0);
    check("rstg_grant", 32'(grant_id), 32'h3);
    check("rstg_underrun", 32'(underrun_cnt), 32'h0);
    @(negedge clk);
    src_valid = 4'hF;
    set_samples(16'h1000);
    @(negedge clk);
    rst_n = 1'b1;
    last_cyc = cyc;
    push(16'h1000, 3'd0, 4'b0001, 8'd11);
    expect_strobe("rstg_first");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
